// File: rtl/text_console_if.sv
// Character-stream write port of the text console, plus the cursor position it reports back.
interface text_console_if;
  logic       char_valid;
  logic [6:0] char_data;
  logic       char_ready;
  logic       clear;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;

  modport master (output char_valid, char_data, clear,
                  input  char_ready, cursor_col, cursor_row);
  modport slave  (input  char_valid, char_data, clear,
                  output char_ready, cursor_col, cursor_row);
endinterface

// File: rtl/text_console.sv
// Text-mode console: COLS x ROWS character buffer with cursor, scrolling and blink,
// rendered as 8x16 glyphs onto a 640x480 pixel stream with a fixed 2-cycle latency.
module text_console #(
  parameter int          COLS         = 80,
  parameter int          ROWS         = 30,
  parameter logic [11:0] FG           = 12'h00F,
  parameter logic [11:0] BG           = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          video_on,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  text_console_if.slave wr,
  output logic [11:0]   rgb
);
  localparam int              CELLS     = COLS * ROWS;
  localparam int              AW        = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int              BW        = $clog2(BLINK_FRAMES + 1);
  localparam logic [6:0]      SPACE     = 7'h20;
  localparam logic [6:0]      LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]      LAST_ROW  = 5'(ROWS - 1);
  localparam logic [AW-1:0]   LAST_ADDR = AW'(CELLS - 1);

  typedef enum logic [1:0] {IDLE, CLR_ALL, CLR_LINE} state_t;

  // Logical row -> physical row through the circular top_row offset.
  function automatic logic [AW-1:0] cell_addr(input logic [4:0] lrow,
                                              input logic [4:0] top,
                                              input logic [6:0] col);
    logic [5:0] sum;
    logic [4:0] prow;
    sum  = {1'b0, lrow} + {1'b0, top};
    prow = (sum >= 6'(ROWS)) ? 5'(sum - 6'(ROWS)) : sum[4:0];
    return AW'(int'(prow) * COLS + int'(col));
  endfunction

  // Glyph ROM: MSB of each row byte is the leftmost pixel; unlisted codes draw a box.
  function automatic logic [7:0] glyph_row(input logic [6:0] code, input logic [3:0] r);
    logic [127:0] g;
    case (code)
      7'h20:   g = '0;
      7'h41:   g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h42:   g = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      default: g = 128'h0000_7E42_4242_4242_4242_4242_427E_0000;
    endcase
    return g[8*(15-int'(r)) +: 8];
  endfunction

  state_t        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [6:0]    clr_cnt_q, clr_cnt_d;
  logic [6:0]    col_q, col_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    top_q, top_d;
  logic          we;
  logic [AW-1:0] waddr;
  logic [6:0]    wdata;
  logic          newrow;

  always_comb begin
    state_d       = state_q;
    clr_addr_d    = clr_addr_q;
    clr_cnt_d     = clr_cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    top_d         = top_q;
    we            = 1'b0;
    waddr         = clr_addr_q;
    wdata         = SPACE;
    newrow        = 1'b0;
    wr.char_ready = 1'b0;
    case (state_q)
      CLR_ALL: begin
        we         = 1'b1;
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == LAST_ADDR) begin
          state_d    = IDLE;
          clr_addr_d = '0;
          col_d      = '0;
          row_d      = '0;
          top_d      = '0;
        end
      end
      CLR_LINE: begin
        we         = 1'b1;
        clr_addr_d = clr_addr_q + AW'(1);
        clr_cnt_d  = clr_cnt_q + 7'd1;
        if (clr_cnt_q == LAST_COL)
          state_d = IDLE;
      end
      IDLE: begin
        wr.char_ready = !wr.clear;
        if (wr.clear) begin
          state_d    = CLR_ALL;
          clr_addr_d = '0;
        end else if (wr.char_valid) begin
          if (wr.char_data >= 7'h20 && wr.char_data <= 7'h7E) begin
            we    = 1'b1;
            waddr = cell_addr(row_q, top_q, col_q);
            wdata = wr.char_data;
            if (col_q == LAST_COL) begin
              col_d  = '0;
              newrow = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end else if (wr.char_data == 7'h0A) begin
            col_d  = '0;
            newrow = 1'b1;
          end else if (wr.char_data == 7'h0D) begin
            col_d = '0;
          end else if (wr.char_data == 7'h08 && col_q != 7'd0) begin
            col_d = col_q - 7'd1;
          end
          if (newrow) begin
            if (row_q != LAST_ROW) begin
              row_d = row_q + 5'd1;
            end else begin
              // The old top physical row becomes the new bottom line and is blanked.
              top_d      = (top_q == LAST_ROW) ? 5'd0 : top_q + 5'd1;
              state_d    = CLR_LINE;
              clr_addr_d = cell_addr(5'd0, top_q, 7'd0);
              clr_cnt_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d    = CLR_ALL;
        clr_addr_d = '0;
      end
    endcase
  end

  assign wr.cursor_col = col_q;
  assign wr.cursor_row = row_q;

  // Blink: count rising edges of the (0,0) pixel, toggle phase every BLINK_FRAMES of them.
  logic          frame_hit, frame_pulse, frame_prev_q;
  logic          blink_q, blink_d;
  logic [BW-1:0] bcnt_q, bcnt_d;

  always_comb begin
    frame_hit   = (x == 10'd0) && (y == 10'd0);
    frame_pulse = frame_hit && !frame_prev_q;
    blink_d     = blink_q;
    bcnt_d      = bcnt_q;
    if (frame_pulse) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        blink_d = !blink_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= CLR_ALL;
      clr_addr_q   <= '0;
      clr_cnt_q    <= '0;
      col_q        <= '0;
      row_q        <= '0;
      top_q        <= '0;
      frame_prev_q <= 1'b0;
      blink_q      <= 1'b0;
      bcnt_q       <= '0;
    end else begin
      state_q      <= state_d;
      clr_addr_q   <= clr_addr_d;
      clr_cnt_q    <= clr_cnt_d;
      col_q        <= col_d;
      row_q        <= row_d;
      top_q        <= top_d;
      frame_prev_q <= frame_hit;
      blink_q      <= blink_d;
      bcnt_q       <= bcnt_d;
    end
  end

  // Display stage C0: cell lookup from the current pixel position.
  logic [6:0]    disp_col;
  logic [4:0]    disp_row;
  logic          in_range, cur_hit;
  logic [AW-1:0] raddr;

  always_comb begin
    disp_col = x[9:3];
    disp_row = y[8:4];
    in_range = (int'(disp_col) < COLS) && (int'(disp_row) < ROWS);
    cur_hit  = (disp_col == col_q) && (disp_row == row_q);
    raddr    = in_range ? cell_addr(disp_row, top_q, disp_col) : '0;
  end

  // Simple dual-port buffer; a same-address read sees the pre-write contents.
  logic [6:0] mem [CELLS];
  logic [6:0] rdata_q;
  logic [7:0] rom_q;
  logic [3:0] yl_d1_q;

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
    rom_q   <= glyph_row(rdata_q, yl_d1_q);
  end

  logic       von_d1_q, von_d2_q, inr_d1_q, inr_d2_q, cur_d1_q, cur_d2_q;
  logic [2:0] bit_d1_q, bit_d2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      von_d1_q <= 1'b0;
      von_d2_q <= 1'b0;
      inr_d1_q <= 1'b0;
      inr_d2_q <= 1'b0;
      cur_d1_q <= 1'b0;
      cur_d2_q <= 1'b0;
      bit_d1_q <= '0;
      bit_d2_q <= '0;
      yl_d1_q  <= '0;
    end else begin
      von_d1_q <= video_on;
      von_d2_q <= von_d1_q;
      inr_d1_q <= in_range;
      inr_d2_q <= inr_d1_q;
      cur_d1_q <= cur_hit;
      cur_d2_q <= cur_d1_q;
      bit_d1_q <= x[2:0];
      bit_d2_q <= bit_d1_q;
      yl_d1_q  <= y[3:0];
    end
  end

  logic [11:0] fg, bg;
  logic        pix;

  always_comb begin
    fg  = FG;
    bg  = BG;
    if (cur_d2_q && blink_q) begin
      fg = BG;
      bg = FG;
    end
    pix = rom_q[~bit_d2_q];
    if (!von_d2_q)
      rgb = '0;
    else if (!inr_d2_q)
      rgb = BG;
    else
      rgb = pix ? fg : bg;
  end
endmodule

// File: tb/tb_text_console.sv
// Bench for text_console: cursor/busy vectors from a table, pixels checked via a
// logical-screen model and an expected-value queue aligned to the 2-cycle display latency.
module tb_text_console;
  localparam int          COLS  = 8;
  localparam int          ROWS  = 4;
  localparam int          BF    = 2;
  localparam int          CELLS = COLS * ROWS;
  localparam logic [11:0] FG    = 12'h00F;
  localparam logic [11:0] BG    = 12'hFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = 10'd639;
  logic [9:0]  y = 10'd479;
  logic [11:0] rgb;

  text_console_if wr();

  text_console #(.COLS(COLS), .ROWS(ROWS), .FG(FG), .BG(BG), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y), .wr(wr), .rgb(rgb)
  );

  always #5 clk = ~clk;

  typedef struct { logic [6:0] code; int ecol; int erow; int ebusy; } cvec_t;
  typedef struct { int px; int py; logic von; logic fixed; logic [11:0] fexp; } stim_t;
  typedef struct { int px; int py; logic von; logic inr; logic bitv; logic cur;
                   logic fixed; logic [11:0] fexp; } exp_t;

  int total = 0;
  int bad = 0;
  int pulses = 0;
  logic prev00 = 1'b0;
  logic [6:0] scr [ROWS][COLS];
  int mcol = 0;
  int mrow = 0;
  cvec_t cv[$];
  stim_t stim_q[$];
  exp_t  exp_q[$];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tb_glyph(input logic [6:0] code, input int r);
    logic [127:0] g;
    case (code)
      7'h20:   g = '0;
      7'h41:   g = 128'h0000_1038_6CC6_C6FE_C6C6_C6C6_0000_0000;
      7'h42:   g = 128'h0000_FC66_6666_7C66_6666_66FC_0000_0000;
      default: g = 128'h0000_7E42_4242_4242_4242_4242_427E_0000;
    endcase
    return 8'(g >> (8 * (15 - r)));
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        scr[r][c] = 7'h20;
    mcol = 0;
    mrow = 0;
  endtask

  task automatic model_char(input logic [6:0] code);
    logic nr;
    nr = 1'b0;
    if (code >= 7'h20 && code <= 7'h7E) begin
      scr[mrow][mcol] = code;
      if (mcol == COLS - 1) begin mcol = 0; nr = 1'b1; end
      else mcol++;
    end else if (code == 7'h0A) begin
      mcol = 0; nr = 1'b1;
    end else if (code == 7'h0D) begin
      mcol = 0;
    end else if (code == 7'h08 && mcol > 0) begin
      mcol--;
    end
    if (nr) begin
      if (mrow < ROWS - 1) mrow++;
      else begin
        for (int r = 0; r < ROWS - 1; r++)
          for (int c = 0; c < COLS; c++)
            scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++)
          scr[ROWS-1][c] = 7'h20;
      end
    end
  endtask

  task automatic drive(input int px, input int py, input logic von);
    logic at00;
    x = 10'(px);
    y = 10'(py);
    video_on = von;
    at00 = (px == 0) && (py == 0);
    if (at00 && !prev00) pulses++;
    prev00 = at00;
  endtask

  task automatic push_exp(input stim_t s);
    exp_t e;
    int c, r;
    logic [7:0] row;
    c = s.px / 8;
    r = s.py / 16;
    e.px = s.px; e.py = s.py; e.von = s.von; e.fixed = s.fixed; e.fexp = s.fexp;
    e.inr = (c < COLS) && (r < ROWS);
    e.bitv = 1'b0;
    e.cur = 1'b0;
    if (e.inr) begin
      row = tb_glyph(scr[r][c], s.py % 16);
      e.bitv = row[7 - (s.px % 8)];
      e.cur = (c == mcol) && (r == mrow);
    end
    exp_q.push_back(e);
  endtask

  task automatic run_stim(input string nm);
    int n, bad0;
    stim_t s;
    exp_t e;
    logic phase;
    logic [11:0] req;
    n = stim_q.size();
    bad0 = bad;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        s = stim_q[i];
        drive(s.px, s.py, s.von);
        push_exp(s);
      end else begin
        drive(639, 479, 1'b0);
      end
      tick();
      if (i >= 1) begin
        e = exp_q.pop_front();
        phase = ((pulses / BF) % 2) == 1;
        if (e.fixed) req = e.fexp;
        else if (!e.von) req = 12'h000;
        else if (!e.inr) req = BG;
        else req = (e.bitv ^ (e.cur && phase)) ? FG : BG;
        chk($sformatf("%s_pix(%0d,%0d)", nm, e.px, e.py), int'(rgb), int'(req));
      end
    end
    stim_q.delete();
    $display("pixels %s: %0d checked, %0d wrong", nm, n, bad - bad0);
  endtask

  task automatic sweep_cell(input int c, input int r, input string nm);
    for (int py = 0; py < 16; py++)
      for (int px = 0; px < 8; px++)
        stim_q.push_back('{c * 8 + px, r * 16 + py, 1'b1, 1'b0, 12'h000});
    run_stim(nm);
  endtask

  task automatic count_busy(output int busy);
    busy = 0;
    while (!wr.char_ready && busy < 5000) begin
      busy++;
      tick();
    end
  endtask

  task automatic send_char(input logic [6:0] code, output int busy);
    int w;
    w = 0;
    while (!wr.char_ready && w < 5000) begin w++; tick(); end
    if (w >= 5000) chk("ready_timeout", 0, 1);
    wr.char_valid = 1'b1;
    wr.char_data = code;
    tick();
    wr.char_valid = 1'b0;
    model_char(code);
    count_busy(busy);
    $display("char 0x%02h -> cursor (%0d,%0d) busy %0d", code, wr.cursor_col, wr.cursor_row, busy);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int busy;
    for (int i = lo; i <= hi; i++) begin
      send_char(cv[i].code, busy);
      chk($sformatf("vec%0d_col", i), int'(wr.cursor_col), cv[i].ecol);
      chk($sformatf("vec%0d_row", i), int'(wr.cursor_row), cv[i].erow);
      chk($sformatf("vec%0d_busy", i), busy, cv[i].ebusy);
    end
  endtask

  initial begin
    int busy;
    wr.char_valid = 1'b0;
    wr.char_data = 7'h00;
    wr.clear = 1'b0;

    cv.push_back('{7'h0D, 0, 0, 0});
    cv.push_back('{7'h41, 1, 0, 0});
    cv.push_back('{7'h43, 2, 0, 0});
    cv.push_back('{7'h44, 3, 0, 0});
    cv.push_back('{7'h45, 4, 0, 0});
    cv.push_back('{7'h46, 5, 0, 0});
    cv.push_back('{7'h47, 6, 0, 0});
    cv.push_back('{7'h48, 7, 0, 0});
    cv.push_back('{7'h49, 0, 1, 0});
    cv.push_back('{7'h08, 0, 1, 0});
    cv.push_back('{7'h42, 1, 1, 0});
    cv.push_back('{7'h08, 0, 1, 0});
    cv.push_back('{7'h01, 0, 1, 0});
    cv.push_back('{7'h7F, 0, 1, 0});
    cv.push_back('{7'h0A, 0, 2, 0});
    cv.push_back('{7'h5A, 1, 2, 0});
    cv.push_back('{7'h0A, 0, 3, 0});
    cv.push_back('{7'h4B, 1, 3, 0});
    cv.push_back('{7'h0A, 0, 3, COLS});
    for (int i = 1; i < COLS; i++)
      cv.push_back('{7'h4D, i, 3, 0});
    cv.push_back('{7'h4D, 0, 3, COLS});

    // Reset: outputs idle while held, then exactly CELLS busy cycles.
    #2 reset = 1'b1;
    drive(100, 100, 1'b1);
    tick(); tick(); tick();
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_ready", int'(wr.char_ready), 0);
    drive(639, 479, 1'b0);
    tick();
    reset = 1'b0;
    pulses = 0;
    model_clear();
    count_busy(busy);
    chk("clr_all_busy", busy, CELLS);
    chk("rst_col", int'(wr.cursor_col), 0);
    chk("rst_row", int'(wr.cursor_row), 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        sweep_cell(c, r, $sformatf("blank_%0d_%0d", c, r));

    // Out-of-range and blanking pixels with constant expectations.
    stim_q.push_back('{100, 10, 1'b1, 1'b1, BG});
    stim_q.push_back('{10, 100, 1'b1, 1'b1, BG});
    stim_q.push_back('{64, 0, 1'b1, 1'b1, BG});
    stim_q.push_back('{0, 64, 1'b1, 1'b1, BG});
    stim_q.push_back('{20, 20, 1'b0, 1'b1, 12'h000});
    stim_q.push_back('{63, 63, 1'b1, 1'b1, BG});
    run_stim("fixed");

    // First character and its glyph.
    send_char(7'h41, busy);
    chk("a_col", int'(wr.cursor_col), 1);
    chk("a_row", int'(wr.cursor_row), 0);
    sweep_cell(0, 0, "glyph_A");

    run_vecs(0, 18);
    sweep_cell(0, 0, "scrolled_B");
    sweep_cell(0, 3, "bottom_blank");
    run_vecs(19, cv.size() - 1);
    sweep_cell(0, 1, "after_wrap_scroll");
    sweep_cell(3, 2, "row_M");

    // clear wins over a simultaneous character.
    wr.clear = 1'b1;
    wr.char_valid = 1'b1;
    wr.char_data = 7'h51;
    #1;
    chk("clear_ready", int'(wr.char_ready), 0);
    tick();
    wr.clear = 1'b0;
    wr.char_valid = 1'b0;
    model_clear();
    count_busy(busy);
    chk("clear_busy", busy, CELLS);
    chk("clear_col", int'(wr.cursor_col), 0);
    chk("clear_row", int'(wr.cursor_row), 0);
    sweep_cell(0, 0, "cleared_00");

    // Cursor blink at (3,2).
    send_char(7'h0A, busy);
    send_char(7'h0A, busy);
    send_char(7'h78, busy);
    send_char(7'h78, busy);
    send_char(7'h78, busy);
    chk("blink_col", int'(wr.cursor_col), 3);
    chk("blink_row", int'(wr.cursor_row), 2);
    for (int k = 0; k < 3; k++) begin
      sweep_cell(3, 2, $sformatf("cursor_ph%0d", k));
      sweep_cell(2, 2, $sformatf("noncursor_ph%0d", k));
      for (int f = 0; f < BF; f++) begin
        drive(0, 0, 1'b1);
        tick();
        drive(639, 479, 1'b0);
        tick();
      end
    end

    // Reset during a line clear restarts the full clear.
    send_char(7'h0A, busy);
    wr.char_valid = 1'b1;
    wr.char_data = 7'h0A;
    tick();
    wr.char_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    pulses = 0;
    prev00 = 1'b0;
    model_clear();
    count_busy(busy);
    chk("midscroll_busy", busy, CELLS);
    chk("midscroll_col", int'(wr.cursor_col), 0);
    chk("midscroll_row", int'(wr.cursor_row), 0);
    sweep_cell(1, 0, "post_reset");

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
